// File: rtl/if_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Fetch states, the nop encoding and the redirect alignment check live here.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_KILL  = 2'd1,
      ST_HOLD  = 2'd2
   } if_state_t;

   localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

   function automatic logic is_misaligned(input logic [1:0] lo);
      return |lo;
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of decode/ctrl/instruction-memory signals around the fetch stage.
// master = fetch stage view, slave = surrounding pipeline and memory view.
interface if_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              stall_i;
   logic              be_i;
   logic [ADDR_W-1:0] baddr_i;
   logic              imem_req_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic              imem_ack_i;
   logic [INST_W-1:0] imem_rdata_i;
   logic [ADDR_W-1:0] pc_o;
   logic [INST_W-1:0] inst_o;
   logic              inst_valid_o;
   logic              ifstallreq_o;
   logic              align_err_o;

   modport master (
      input  stall_i, be_i, baddr_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o,
      output ifstallreq_o, align_err_o
   );

   modport slave (
      output stall_i, be_i, baddr_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o,
      input  ifstallreq_o, align_err_o
   );
endinterface

// File: rtl/if_fetch_if_id_buf.sv
// IF/ID pipeline register: bubble wins over load, otherwise contents are held.
module if_id_buf #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_bubble,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [INST_W-1:0] i_inst,
   output logic [ADDR_W-1:0] o_pc,
   output logic [INST_W-1:0] o_inst,
   output logic              o_valid
);
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic              r_valid;

   always_ff @(posedge clk) begin
      if (rst || i_bubble) begin
         r_pc    <= '0;
         r_inst  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_inst  <= i_inst;
         r_valid <= 1'b1;
      end
   end

   assign o_pc    = r_pc;
   assign o_inst  = r_inst;
   assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, runs one-outstanding req/ack fetches and
// squashes wrong-path data after a redirect from decode.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic        clk,
   input logic        rst,
   if_fetch_if.master bus
);
   if_state_t         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_kill, w_kill_nxt;
   logic [ADDR_W-1:0] r_hb_pc;
   logic [INST_W-1:0] r_hb_inst;
   logic              r_align_err;
   logic              w_hb_we, w_load, w_bubble;
   logic [ADDR_W-1:0] w_ld_pc;
   logic [INST_W-1:0] w_ld_inst;
   logic              w_redir;
   logic [ADDR_W-1:0] w_tgt;
   logic [ADDR_W-1:0] w_pc_inc;

   // A redirect raised during a stall is ignored; decode re-presents it later.
   assign w_redir  = bus.be_i && !bus.stall_i;
   assign w_tgt    = {bus.baddr_i[ADDR_W-1:2], 2'b00};
   assign w_pc_inc = r_pc + ADDR_W'(4);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_hb_we     = 1'b0;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_ld_pc     = r_pc;
      w_ld_inst   = bus.imem_rdata_i;
      case (r_state)
         ST_FETCH: begin
            if (bus.imem_ack_i) begin
               if (bus.stall_i) begin
                  w_hb_we     = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = ST_HOLD;
               end else if (bus.be_i) begin
                  w_pc_nxt = w_tgt;
                  w_bubble = 1'b1;
               end else begin
                  w_load   = 1'b1;
                  w_pc_nxt = w_pc_inc;
               end
            end else if (w_redir) begin
               w_kill_nxt  = w_tgt;
               w_bubble    = 1'b1;
               w_state_nxt = ST_KILL;
            end else if (!bus.stall_i) begin
               w_bubble = 1'b1;
            end
         end
         ST_KILL: begin
            if (w_redir) w_kill_nxt = w_tgt;
            if (!bus.stall_i) w_bubble = 1'b1;
            // The in-flight response belongs to the old path and is dropped.
            if (bus.imem_ack_i) begin
               w_pc_nxt    = w_kill_nxt;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (!bus.stall_i) begin
               w_state_nxt = ST_FETCH;
               if (bus.be_i) begin
                  w_pc_nxt = w_tgt;
                  w_bubble = 1'b1;
               end else begin
                  w_load    = 1'b1;
                  w_ld_pc   = r_hb_pc;
                  w_ld_inst = r_hb_inst;
               end
            end
         end
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FETCH;
         r_pc        <= RESET_PC;
         r_kill      <= '0;
         r_hb_pc     <= '0;
         r_hb_inst   <= '0;
         r_align_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
         if (w_hb_we) begin
            r_hb_pc   <= r_pc;
            r_hb_inst <= bus.imem_rdata_i;
         end
         if (w_redir && is_misaligned(bus.baddr_i[1:0])) r_align_err <= 1'b1;
      end
   end

   if_id_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_if_id_buf (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_pc     (w_ld_pc),
      .i_inst   (w_ld_inst),
      .o_pc     (bus.pc_o),
      .o_inst   (bus.inst_o),
      .o_valid  (bus.inst_valid_o)
   );

   assign bus.imem_req_o   = !rst && (r_state == ST_FETCH || r_state == ST_KILL);
   assign bus.imem_addr_o  = r_pc;
   assign bus.ifstallreq_o = bus.imem_req_o && !bus.imem_ack_i;
   assign bus.align_err_o  = r_align_err;
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register.
- It is the consumer end of the decode stage's redirect interface (be/baddr) and sits between the instruction memory and decode.
- It owns the PC and issues one-outstanding req/ack fetches to instruction memory.
- It presents pc/inst to decode and discards wrong-path fetch data after a redirect.
- It reports its own stall request to ctrl while a fetch is pending.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, instruction address width
INST_W, 32, instruction width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high (RST_ENABLE=1)
stall_i  in  1  ctrl hold of IF/ID; outputs and PC frozen except as stated below
be_i  in  1  redirect request from decode; honoured only when stall_i=0
baddr_i  in  ADDR_W  redirect target
imem_req_o  out  1  fetch request, held until ack
imem_addr_o  out  ADDR_W  fetch address, stable while req high
imem_ack_i  in  1  fetch complete; imem_rdata_i valid this cycle
imem_rdata_i  in  INST_W  fetched instruction
pc_o  out  ADDR_W  IF/ID pc of inst_o
inst_o  out  INST_W  IF/ID instruction (32'h0 = nop bubble)
inst_valid_o  out  1  IF/ID holds a real instruction
ifstallreq_o  out  1  fetch pending, to ctrl
align_err_o  out  1  sticky: a redirect target had baddr_i[1:0]!=0

Behaviour:
- Reset (rst=1 at posedge):
  - pc<=RESET_PC, state<=FETCH.
  - pc_o<=0, inst_o<=0, inst_valid_o<=0, align_err_o<=0, hold buffer cleared, kill target<=0.
  - While rst=1: imem_req_o=0, ifstallreq_o=0.
  - Reset mid-fetch abandons the request; a late ack after reset while state=FETCH is treated as a response to the new RESET_PC request. The memory must not ack without a req.
- Bubble = inst_o<=0, inst_valid_o<=0, pc_o<=0.
- Redirect target used = {baddr_i[ADDR_W-1:2],2'b00}. If baddr_i[1:0]!=0, align_err_o<=1 (sticky).
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - ack, be_i=0, stall_i=0: pc_o<=pc, inst_o<=rdata, inst_valid_o<=1, pc<=pc+4. Stay in FETCH; next req is issued the following cycle.
  - ack, stall_i=1: capture {pc,rdata} into the hold buffer, pc<=pc+4, go to HOLD. IF/ID outputs are unchanged.
  - ack, be_i=1, stall_i=0: discard rdata, pc<=target, IF/ID<=bubble, stay in FETCH.
  - no ack, be_i=1, stall_i=0: kill<=target, IF/ID<=bubble, go to KILL. Req stays high with the old address.
  - no ack, stall_i=0, be_i=0: IF/ID<=bubble.
  - no ack, stall_i=1: IF/ID held.
- KILL: imem_req_o=1, imem_addr_o=old pc.
  - be_i=1 with stall_i=0: kill<=new target (last one wins), IF/ID<=bubble.
  - On ack: discard rdata, pc<=kill target, go to FETCH.
  - stall_i=0 and no new be_i: IF/ID<=bubble.
- HOLD: imem_req_o=0.
  - stall_i=1: everything held.
  - stall_i=0, be_i=0: IF/ID<=buffer, inst_valid_o<=1, go to FETCH.
  - stall_i=0, be_i=1: drop the buffer, pc<=target, IF/ID<=bubble, go to FETCH.
- ifstallreq_o = (state==FETCH || state==KILL) && !imem_ack_i && !rst. Combinational.
- Latency: redirect to first fetch request at the target is 1 cycle when no fetch is in flight. Zero-wait memory gives 1 instruction per cycle.
- pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- Simultaneous be_i and stall_i: be_i is ignored; decode must re-present it after the stall.

Decomposition:
- Shared define file (DEFINE.v): IF state encodings (FETCH/KILL/HOLD), and the existing RST_ENABLE, ZERO_WORD, STALLREQ_ENABLE/DISABLE, BRANCH_ENABLE, INST_ADDR_BUS, INST_BUS macros.
- One natural sub-module: if_id_buf, the IF/ID output register with hold/bubble/load controls. The FSM and PC stay in if_fetch.

Test Plan:
- Zero-wait memory (ack every cycle with req), rdata=addr^32'hA5A5_0000 → pc_o 0,4,8,... on consecutive cycles, inst_valid_o=1 continuously, ifstallreq_o=0.
- ack delayed 3 cycles at pc=8 → imem_addr_o=8 held for 4 cycles, ifstallreq_o=1 for 3 cycles, 3 bubbles, then pc_o=8.
- be_i=1, baddr_i=32'h40 during the pending fetch of pc=0x10 (ack 2 cycles later) → state KILL, the 0x10 data never appears on inst_o, next imem_addr_o=0x40, first valid pc_o=0x40.
- stall_i=1 for 2 cycles while the ack for pc=0x20 arrives → IF/ID unchanged, req drops, after stall_i falls pc_o=0x20 valid, next fetch 0x24.
- be_i=1, baddr_i=32'h42 with stall_i=0 → fetch at 0x40, align_err_o=1 and stays 1 until rst.
- rst=1 while req is pending at 0x30 → next cycle imem_req_o=0, all outputs 0; after rst falls imem_addr_o=RESET_PC.
